output_display: RTL and testbench

//  Consumes the 8-bit value held by output_register (out_data) and shows it in decimal on a
//  3-digit multiplexed 7-segment display. Conversion uses iterative double-dabble, one bit per

---
 rtl/output_display.sv | 173 +++++++++++++++++
 tb/tb_output_display.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/output_display.sv
// Shows an 8-bit value in decimal on a 3-digit multiplexed 7-segment display.
// Binary-to-BCD uses iterative double-dabble (one bit per clock); a divider scans the digits.
module output_display #(
  parameter int REFRESH_DIV   = 4,
  parameter bit COMMON_ANODE  = 1'b1,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic [3:0] bcd_hundreds,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_ZERO_RAW = 7'h3F;
  localparam logic [6:0] SEG_RST = COMMON_ANODE ? ~SEG_ZERO_RAW : SEG_ZERO_RAW;
  localparam logic [2:0] AN_RST  = COMMON_ANODE ? 3'b110 : 3'b001;

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic [7:0]       last_val_q, last_val_d;
  logic [7:0]       shift_q, shift_d;
  logic [11:0]      scratch_q, scratch_d;
  logic [2:0]       iter_q, iter_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]       dig_idx_q, dig_idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [2:0]       an_q, an_d;

  logic [11:0]      adjusted;
  logic [19:0]      shifted;

  function automatic logic [11:0] dabble_adjust(input logic [11:0] s);
    logic [11:0] r;
    r = s;
    for (int i = 0; i < 3; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'd0: c = 7'h3F;
      4'd1: c = 7'h06;
      4'd2: c = 7'h5B;
      4'd3: c = 7'h4F;
      4'd4: c = 7'h66;
      4'd5: c = 7'h6D;
      4'd6: c = 7'h7D;
      4'd7: c = 7'h07;
      4'd8: c = 7'h7F;
      4'd9: c = 7'h6F;
      default: c = 7'h00;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    last_val_d = last_val_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    iter_d     = iter_q;
    bcd_d      = bcd_q;
    adjusted   = dabble_adjust(scratch_q);
    shifted    = {adjusted[10:0], shift_q, 1'b0};
    case (state_q)
      IDLE: begin
        if (data_in != last_val_q) begin
          last_val_d = data_in;
          shift_d    = data_in;
          scratch_d  = 12'd0;
          iter_d     = 3'd0;
          busy_d     = 1'b1;
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        scratch_d = shifted[19:8];
        shift_d   = shifted[7:0];
        iter_d    = iter_q + 3'd1;
        // Publish all three digits together so bcd_* never shows a partial result.
        if (iter_q == 3'd7) begin
          bcd_d   = shifted[19:8];
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [3:0] nib;
  logic       lit;
  logic [2:0] an_onehot;
  logic       hund_blank, tens_blank;
  logic [6:0] seg_raw;
  logic [2:0] an_raw;

  always_comb begin
    ref_cnt_d = ref_cnt_q + CNT_W'(1);
    dig_idx_d = dig_idx_q;
    if (ref_cnt_q == CNT_LAST) begin
      ref_cnt_d = '0;
      dig_idx_d = (dig_idx_q == 2'd2) ? 2'd0 : dig_idx_q + 2'd1;
    end

    hund_blank = BLANK_LEADING && (bcd_q[11:8] == 4'd0);
    tens_blank = hund_blank && (bcd_q[7:4] == 4'd0);
    nib        = 4'd0;
    lit        = 1'b0;
    an_onehot  = 3'b000;
    case (dig_idx_q)
      2'd0: begin nib = bcd_q[3:0];  lit = 1'b1;        an_onehot = 3'b001; end
      2'd1: begin nib = bcd_q[7:4];  lit = !tens_blank; an_onehot = 3'b010; end
      2'd2: begin nib = bcd_q[11:8]; lit = !hund_blank; an_onehot = 3'b100; end
      default: begin nib = 4'd0; lit = 1'b0; an_onehot = 3'b000; end
    endcase
    seg_raw = lit ? seg_code(nib) : 7'h00;
    an_raw  = lit ? an_onehot : 3'b000;
    seg_d   = COMMON_ANODE ? ~seg_raw : seg_raw;
    an_d    = COMMON_ANODE ? ~an_raw  : an_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      last_val_q <= 8'd0;
      bcd_q      <= 12'd0;
      ref_cnt_q  <= '0;
      dig_idx_q  <= 2'd0;
      seg_q      <= SEG_RST;
      an_q       <= AN_RST;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      last_val_q <= last_val_d;
      bcd_q      <= bcd_d;
      ref_cnt_q  <= ref_cnt_d;
      dig_idx_q  <= dig_idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  // Conversion scratch is fully reloaded on entry to CONVERT, so it needs no reset.
  always_ff @(posedge clk) begin
    shift_q   <= shift_d;
    scratch_q <= scratch_d;
    iter_q    <= iter_d;
  end

  assign busy         = busy_q;
  assign bcd_hundreds = bcd_q[11:8];
  assign bcd_tens     = bcd_q[7:4];
  assign bcd_ones     = bcd_q[3:0];
  assign seg          = seg_q;
  assign an           = an_q;

endmodule

// File: tb/tb_output_display.sv
// Scoreboarded bench: two display variants share stimulus; a decimal reference model
// predicts conversion results and the scanned digit pattern.
module tb_output_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;

  logic       busy_a, busy_b;
  logic [3:0] h_a, t_a, o_a, h_b, t_b, o_b;
  logic [6:0] seg_a, seg_b;
  logic [2:0] an_a, an_b;

  output_display #(.REFRESH_DIV(4), .COMMON_ANODE(1'b1), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .busy(busy_a),
    .bcd_hundreds(h_a), .bcd_tens(t_a), .bcd_ones(o_a), .seg(seg_a), .an(an_a));

  output_display #(.REFRESH_DIV(1), .COMMON_ANODE(1'b0), .BLANK_LEADING(1'b0)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .busy(busy_b),
    .bcd_hundreds(h_b), .bcd_tens(t_b), .bcd_ones(o_b), .seg(seg_b), .an(an_b));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Expected {an,seg} when digit position p of decimal value v is being scanned.
  function automatic int exp_disp(input int v, input int p, input bit bl, input bit ca);
    int d, a, s;
    bit lit;
    d   = (p == 0) ? v % 10 : (p == 1) ? (v / 10) % 10 : v / 100;
    lit = !bl || (p == 0) || (p == 1 && v >= 10) || (p == 2 && v >= 100);
    a   = lit ? (1 << p) : 0;
    s   = lit ? int'(segtab[d]) : 0;
    if (ca) begin a = (~a) & 7; s = (~s) & 8'h7F; end
    return (a << 7) | s;
  endfunction

  // Monitor / scoreboard
  bit rst_seen = 0, started = 0, busy_prev = 0;
  int k = 0, busy_cnt = 0, disp_cur = 0, disp_prev = 0;

  always @(negedge clk) begin
    int v, e;
    if (rst_seen) begin
      k = 0; started = 1; busy_cnt = 0; disp_cur = 0;
      chk("reset_busy", {busy_a, busy_b}, 0);
      chk("reset_bcd", {h_a, t_a, o_a, h_b, t_b, o_b}, 0);
    end else if (started) begin
      k++;
    end
    if (started) begin
      v = (k == 0) ? 0 : disp_prev;
      chk("scan_div4", {an_a, seg_a}, exp_disp(v, (k == 0) ? 0 : ((k - 1) / 4) % 3, 1'b1, 1'b1));
      chk("scan_div1", {an_b, seg_b}, exp_disp(v, (k == 0) ? 0 : (k - 1) % 3, 1'b0, 1'b0));
      if (k != 0) begin
        if (busy_a) busy_cnt++;
        if (busy_prev && !busy_a) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_conversion", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("bcd_a", {h_a, t_a, o_a}, ((e / 100) << 8) | (((e / 10) % 10) << 4) | (e % 10));
            chk("bcd_b", {h_b, t_b, o_b}, ((e / 100) << 8) | (((e / 10) % 10) << 4) | (e % 10));
            chk("busy_len", busy_cnt, 8);
            disp_cur = e;
          end
          busy_cnt = 0;
        end
        if (busy_a != busy_b) chk("busy_match", busy_b, busy_a);
      end
    end
    disp_prev = disp_cur;
    busy_prev = busy_a;
    rst_seen  = rst;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done();
    bit done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !busy_a) done = 1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout: pending=%0d busy=%0b expected empty/0", exp_q.size(), busy_a);
      exp_q.delete();
    end
  endtask

  int last;

  initial begin
    rst = 1'b1; data_in = 8'd0;
    tick(2);                      // T1: reset two clocks, value 0 never converts
    rst = 1'b0;
    tick(14);
    last = 0;

    data_in = 8'd255; exp_q.push_back(255); last = 255; wait_done(); tick(15);   // T2
    data_in = 8'd7;   exp_q.push_back(7);   last = 7;   wait_done(); tick(15);   // T3

    data_in = 8'd100; exp_q.push_back(100);                                       // T4
    tick(4);
    data_in = 8'd42;  exp_q.push_back(42);  last = 42;  wait_done(); tick(6);

    data_in = 8'd199; exp_q.push_back(199);                                       // T5
    tick(4);
    rst = 1'b1; exp_q.delete();
    tick(1);
    rst = 1'b0; exp_q.push_back(199); last = 199; wait_done(); tick(8);

    data_in = 8'd128; exp_q.push_back(128); last = 128; wait_done(); tick(20);   // T6

    for (int i = 0; i < 25; i++) begin
      int v, w;
      v = $urandom_range(0, 255);
      data_in = 8'(v);
      if (v != last) begin
        exp_q.push_back(v);
        last = v;
        if ($urandom_range(0, 2) == 0) begin
          tick(1 + $urandom_range(0, 6));
          w = $urandom_range(0, 255);
          data_in = 8'(w);
          if (w != v) begin exp_q.push_back(w); last = w; end
        end
        wait_done();
      end
      tick($urandom_range(0, 8));
    end
    tick(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
